// File: rtl/mem_responder.sv
// mem_responder: word-addressed 32-bit RAM behind a MAR/MDR-style strobe interface.
// Latency: done first high WAIT_CYCLES+1 edges after the request is sampled in IDLE.
// Backpressure: four-phase handshake; done is held until read/write drop, and no new
//               request is taken until the FSM has returned to IDLE.
// Optional feature: define MEM_ERR_EN to add the err output (out-of-range / dual strobe).
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic                  read,
  input  logic                  write,
  output logic [31:0]           mdatain,
  output logic                  done
`ifdef MEM_ERR_EN
  ,
  output logic                  err
`endif
);

  // Counter is at least one bit wide so a zero-wait build still elaborates.
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // RAM index width; addresses at or above DEPTH are rejected before indexing.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] DEPTH_EXT = AW1'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    op_wr_q, op_wr_d;
  logic [31:0]             mdatain_q, mdatain_d;
  logic                    done_q, done_d;
`ifdef MEM_ERR_EN
  logic                    err_q, err_d;
`endif

  logic [31:0]             mem_q [DEPTH];

  logic                    req_one;
  logic                    req_both;
  logic                    req_any;
  logic                    enter_done;
  logic [ADDR_WIDTH-1:0]   eff_addr;
  logic [31:0]             eff_wdata;
  logic                    eff_wr;
  logic                    in_range;
  logic [IDX_W-1:0]        ram_idx;
  logic [31:0]             ram_rd;
  logic                    ram_we;

  assign req_one  = read ^ write;
  assign req_both = read & write;
  assign req_any  = read | write;

  // Effective request: live inputs when accepting from IDLE (zero-wait path), latched copy otherwise.
  always_comb begin
    eff_addr  = addr_q;
    eff_wdata = wdata_q;
    eff_wr    = op_wr_q;
    if (state_q == S_IDLE) begin
      eff_addr  = addr;
      eff_wdata = wdata;
      eff_wr    = write;
    end
  end

  assign in_range = ({1'b0, eff_addr} < DEPTH_EXT);
  assign ram_idx  = eff_addr[IDX_W-1:0];
  assign ram_rd   = mem_q[ram_idx];

  // The edge that moves the FSM into DONE is where the RAM access and done assertion happen.
  always_comb begin
    enter_done = 1'b0;
    if (state_q == S_IDLE && req_one && WAIT_CYCLES == 0) begin
      enter_done = 1'b1;
    end else if (state_q == S_BUSY && cnt_q == CNT_ONE) begin
      enter_done = 1'b1;
    end
  end

  // State and datapath registers; clr wins over every other event.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_wr_q   <= 1'b0;
      mdatain_q <= '0;
      done_q    <= 1'b0;
`ifdef MEM_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_wr_q   <= op_wr_d;
      mdatain_q <= mdatain_d;
      done_q    <= done_d;
`ifdef MEM_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  // RAM array: never cleared; a write caught by clr is dropped.
  always_ff @(posedge clk) begin
    if (ram_we && !clr) begin
      mem_q[ram_idx] <= eff_wdata;
    end
  end

  // Next-state and request-latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    case (state_q)
      S_IDLE: begin
        // A dual strobe is not a valid request and leaves the FSM in IDLE.
        if (req_one) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_wr_d = write;
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_BUSY: begin
        // Inputs are ignored here; only the latched request matters.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!req_any) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output and RAM-port logic.
  always_comb begin
    mdatain_d = mdatain_q;
    done_d    = done_q;
    ram_we    = 1'b0;
`ifdef MEM_ERR_EN
    err_d     = err_q;
`endif
    if (enter_done) begin
      done_d = 1'b1;
      if (eff_wr) begin
        // Out-of-range writes are silently discarded.
        ram_we = in_range;
      end else begin
        mdatain_d = in_range ? ram_rd : 32'd0;
      end
`ifdef MEM_ERR_EN
      err_d = !in_range;
`endif
    end else if (state_q == S_DONE && !req_any) begin
      done_d = 1'b0;
`ifdef MEM_ERR_EN
      err_d  = 1'b0;
`endif
    end else if (state_q == S_IDLE) begin
`ifdef MEM_ERR_EN
      // One-cycle pulse per sampled dual strobe.
      err_d = req_both;
`endif
    end
  end

  assign mdatain = mdatain_q;
  assign done    = done_q;
`ifdef MEM_ERR_EN
  assign err     = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_CYCLES=2/DEPTH=512 and WAIT_CYCLES=0/DEPTH=256)
// driven by transaction tasks; a per-instance model of RAM contents and expected outputs
// is compared against the DUTs every cycle, plus literal spot checks.
module tb_mem_responder;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr  [NI];
  logic        rd   [NI];
  logic        wr   [NI];
  logic [8:0]  a    [NI];
  logic [31:0] wd   [NI];
  logic [31:0] mdat [NI];
  logic        done [NI];
`ifdef MEM_ERR_EN
  logic        err  [NI];
`endif

  // Behavioural model state
  logic [31:0] mm     [NI][512];
  logic [31:0] e_mdat [NI];
  logic        e_done [NI];
  logic        e_err  [NI];

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  mem_responder #(.ADDR_WIDTH(9), .DEPTH(512), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .clr(clr[0]), .addr(a[0]), .wdata(wd[0]),
    .read(rd[0]), .write(wr[0]), .mdatain(mdat[0]), .done(done[0])
`ifdef MEM_ERR_EN
    , .err(err[0])
`endif
  );

  mem_responder #(.ADDR_WIDTH(9), .DEPTH(256), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .clr(clr[1]), .addr(a[1]), .wdata(wd[1]),
    .read(rd[1]), .write(wr[1]), .mdatain(mdat[1]), .done(done[1])
`ifdef MEM_ERR_EN
    , .err(err[1])
`endif
  );

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int depth(input int k);
    return (k == 0) ? 512 : 256;
  endfunction

  function automatic logic [31:0] init_val(input int k, input int ad);
    return 32'hA500_0000 | (32'(k) << 16) | 32'(ad);
  endfunction

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
  endfunction

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("done%0d", k), {31'd0, done[k]}, {31'd0, e_done[k]});
        check($sformatf("mdatain%0d", k), mdat[k], e_mdat[k]);
`ifdef MEM_ERR_EN
        check($sformatf("err%0d", k), {31'd0, err[k]}, {31'd0, e_err[k]});
`endif
      end
    end
  end

  // Apply the spec's completion rule to the model: RAM update or read result, done, err.
  task automatic model_complete(input int k, input bit is_wr, input logic [8:0] ad, input logic [31:0] d);
    bit oob;
    oob = (int'(ad) >= depth(k));
    e_done[k] = 1'b1;
    e_err[k]  = oob;
    if (is_wr) begin
      if (!oob) mm[k][ad] = d;
    end else begin
      e_mdat[k] = oob ? 32'd0 : mm[k][ad];
    end
  endtask

  // One full four-phase transaction; optional input scrambling while busy/holding.
  task automatic txn(input int k, input bit is_wr, input logic [8:0] ad, input logic [31:0] d,
                     input int hold, input bit perturb);
    @(negedge clk);
    rd[k] = !is_wr; wr[k] = is_wr; a[k] = ad; wd[k] = d;
    @(posedge clk);
    for (int i = 0; i < wc(k); i++) begin
      @(negedge clk);
      if (perturb) begin a[k] = 9'($urandom); wd[k] = $urandom; end
      @(posedge clk);
    end
    #1 model_complete(k, is_wr, ad, d);
    repeat (hold) begin
      @(negedge clk);
      if (perturb) a[k] = 9'($urandom);
    end
    @(negedge clk);
    rd[k] = 1'b0; wr[k] = 1'b0;
    @(posedge clk);
    #1 e_done[k] = 1'b0; e_err[k] = 1'b0;
  endtask

  task automatic dual(input int k);
    @(negedge clk);
    rd[k] = 1'b1; wr[k] = 1'b1; a[k] = 9'($urandom); wd[k] = $urandom;
    @(posedge clk);
    #1 e_err[k] = 1'b1;
    @(negedge clk);
    rd[k] = 1'b0; wr[k] = 1'b0;
    @(posedge clk);
    #1 e_err[k] = 1'b0;
  endtask

  // Reset asserted one edge after sampling (mid-BUSY) or right after completion (mid-DONE).
  task automatic rst_mid(input int k, input bit is_wr, input logic [8:0] ad, input logic [31:0] d,
                         input bit after_done);
    @(negedge clk);
    rd[k] = !is_wr; wr[k] = is_wr; a[k] = ad; wd[k] = d;
    @(posedge clk);
    if (after_done || wc(k) == 0) begin
      repeat (wc(k)) @(posedge clk);
      #1 model_complete(k, is_wr, ad, d);
    end
    @(negedge clk);
    clr[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0;
    @(posedge clk);
    #1 e_done[k] = 1'b0; e_mdat[k] = 32'd0; e_err[k] = 1'b0;
    @(negedge clk);
    clr[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [8:0] ad;
    int k;
    int r;

    for (int i = 0; i < NI; i++) begin
      clr[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; a[i] = '0; wd[i] = '0;
      e_done[i] = 1'b0; e_mdat[i] = 32'd0; e_err[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("reset_done0", {31'd0, done[0]}, 32'd0);
    check("reset_mdat0", mdat[0], 32'd0);
    check("reset_mdat1", mdat[1], 32'd0);
    clr[0] = 1'b0; clr[1] = 1'b0;

    // Known RAM contents for both instances.
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < depth(i); j++)
        txn(i, 1'b1, 9'(j), init_val(i, j), 0, 1'b0);

    // Write then read with latency measurement and a long handshake hold.
    txn(0, 1'b1, 9'd5, 32'h1234_5678, 0, 1'b0);
    lat = 0;
    fork
      txn(0, 1'b0, 9'd5, 32'd0, 6, 1'b0);
      begin
        @(negedge clk);
        @(posedge clk);
        lat = 1;
        #1;
        while (done[0] !== 1'b1 && lat < 10) begin
          @(posedge clk);
          #1 lat++;
        end
      end
    join
    check("read_latency", 32'(lat), 32'd3);
    check("read5_value", mdat[0], 32'h1234_5678);

    // Reset mid-BUSY drops the pending write to addr 5.
    rst_mid(0, 1'b1, 9'd5, 32'hAAAA_5555, 1'b0);
    check("rst_mdat", mdat[0], 32'd0);
    txn(0, 1'b0, 9'd5, 32'd0, 0, 1'b0);
    check("rst_no_write", mdat[0], 32'h1234_5678);

    // Address/data changes while busy are ignored.
    txn(0, 1'b1, 9'd5, 32'hCAFE_F00D, 1, 1'b1);
    txn(0, 1'b0, 9'd5, 32'd0, 0, 1'b0);
    check("stable_addr5", mdat[0], 32'hCAFE_F00D);
    txn(0, 1'b0, 9'd6, 32'd0, 0, 1'b0);
    check("stable_addr6", mdat[0], 32'hA500_0006);
    txn(0, 1'b1, 9'd7, 32'h0BAD_0BAD, 0, 1'b0);
    check("mdat_held_on_write", mdat[0], 32'hA500_0006);

    // Zero-wait instance.
    txn(1, 1'b1, 9'd0, 32'hDEAD_BEEF, 0, 1'b0);
    txn(1, 1'b0, 9'd0, 32'd0, 2, 1'b0);
    check("w0_read0", mdat[1], 32'hDEAD_BEEF);

    // Out-of-range on the DEPTH=256 instance.
    txn(1, 1'b0, 9'd300, 32'd0, 1, 1'b0);
    check("oob_read", mdat[1], 32'd0);
    txn(1, 1'b1, 9'd300, 32'h5555_AAAA, 0, 1'b0);
    txn(1, 1'b0, 9'd44, 32'd0, 0, 1'b0);
    check("oob_write_dropped", mdat[1], 32'hA501_002C);

    // Dual strobes are ignored by both instances.
    dual(0);
    dual(1);
    check("dual_no_done0", {31'd0, done[0]}, 32'd0);

    // Reset mid-DONE on both instances.
    rst_mid(0, 1'b0, 9'd5, 32'd0, 1'b1);
    rst_mid(1, 1'b1, 9'd9, 32'h0909_0909, 1'b1);
    txn(1, 1'b0, 9'd9, 32'd0, 0, 1'b0);
    check("rst_after_done_write", mdat[1], 32'h0909_0909);

    // Randomized traffic.
    for (int it = 0; it < 250; it++) begin
      k  = $urandom_range(0, 1);
      r  = $urandom_range(0, 19);
      ad = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
      if (r == 0) dual(k);
      else if (r == 1) rst_mid(k, 1'($urandom_range(0, 1)), ad, $urandom, 1'($urandom_range(0, 1)));
      else txn(k, 1'($urandom_range(0, 1)), ad, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the datapath's MAR/MDR memory interface: accepts read/write strobes with an address and write data, holds a word-addressed RAM, and returns read data on mdatain with a done handshake.
- Read data feeds the MDR's mdatain input. Write data comes from MDRout and the address from the MAR.
- Models fixed wait-state latency so the control unit's memory-wait sequencing can be exercised.

Parameters:
- ADDR_WIDTH, 9, width of addr port.
- DEPTH, 512, number of 32-bit words; valid addresses 0..DEPTH-1.
- WAIT_CYCLES, 2, extra busy cycles before done; 0 allowed.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- clr  input  1  reset; one clock; reset is synchronous and active-high.
- addr  input  ADDR_WIDTH  word address (from MAR).
- wdata  input  32  write data (from MDRout).
- read  input  1  read request strobe, level, held until done seen.
- write  input  1  write request strobe, level, held until done seen.
- mdatain  output  32  read data to MDR, registered.
- done  output  1  request complete, registered.
- err  output  1  present only with MEM_ERR_EN; see Optional Feature.

Behaviour:
- States: IDLE, BUSY, DONE. Wait counter is clog2(WAIT_CYCLES+1) bits.
- Reset (clr high at an edge):
  - state becomes IDLE; mdatain=0; done=0; counter=0; err=0.
  - RAM contents are NOT cleared.
  - clr wins over every other event, including mid-BUSY or mid-DONE; any in-flight write is dropped with no RAM update.
- IDLE:
  - Exactly one of read/write high at edge N: latch addr, wdata and op.
  - Then go to BUSY with counter=WAIT_CYCLES, or straight to DONE if WAIT_CYCLES=0.
  - read and write both high: ignored, stay IDLE (err pulses if enabled).
  - Neither high: stay IDLE.
- BUSY:
  - Decrement counter each edge. When counter==1, next state is DONE.
  - Strobe or addr/wdata changes during BUSY are ignored; the latched values are used.
- On the edge entering DONE:
  - Write: RAM[latched addr] <= latched wdata.
  - Read: mdatain <= RAM[latched addr].
  - done <= 1.
- Latency: done first high in the cycle after edge N+WAIT_CYCLES; that is, WAIT_CYCLES+1 edges from the sampling edge.
- DONE:
  - done stays high while read or write remains high (four-phase handshake).
  - On the first edge with both low: done <= 0, state IDLE.
  - A new request is accepted no earlier than the edge after returning to IDLE.
- mdatain holds the last read value through writes and idle periods; it changes only on read completion or clr.
- Address out of range (addr >= DEPTH, only possible when DEPTH < 2^ADDR_WIDTH):
  - read returns 0.
  - write is discarded.
  - The handshake completes normally.
- Read-after-write to the same address in consecutive transactions returns the new data.

Optional Feature:
- Macro MEM_ERR_EN.
- When defined:
  - err output exists, registered, reset 0.
  - err is set with done for out-of-range accesses and cleared with done.
  - err pulses high for exactly one cycle when read and write are both high in IDLE.
- When undefined:
  - No err port.
  - Out-of-range and dual-strobe cases behave as above, silently.

Test Plan:
- Reset: drive clr=1 for one edge mid-BUSY -> mdatain=0, done=0, state IDLE next cycle; a write pending to addr 5 leaves RAM[5] unchanged.
- Write then read: write 0x12345678 to addr 5, hold until done, drop strobe; then read addr 5 -> mdatain=0x12345678, done first high 3 edges after request sampled (WAIT_CYCLES=2).
- Handshake hold: keep read high 6 cycles after done -> done stays 1 throughout; falls 1 edge after read drops; new read issued in the same cycle done falls is not accepted until IDLE.
- WAIT_CYCLES=0 build: read addr 0 after writing 0xDEADBEEF -> done high after the single sampling edge, mdatain=0xDEADBEEF.
- Input stability: change addr from 5 to 6 and wdata during BUSY -> write lands at addr 5 with the originally latched data; RAM[6] unchanged.
- MEM_ERR_EN, DEPTH=256:
  - Read addr 300 -> mdatain=0, done=1, err=1.
  - read=write=1 in IDLE -> err high for 1 cycle, done stays 0, state IDLE.
